// File: rtl/pri_dec3x8_buf.sv
// pri_dec3x8_buf: FIFO of 3-bit priority indices with one-hot decoded head, sticky seen mask and pop counter
module pri_dec3x8_buf #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [2:0]               in_idx,
  output logic                     in_ready,
  output logic [7:0]               Y,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     seen_clr,
  output logic [7:0]               seen,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               pop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push, pop;
  assign in_ready  = level < (AW+1)'(DEPTH);
  assign out_valid = level != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;
  assign Y         = out_valid ? 8'b1 << mem[rp] : 8'h00;
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      level   <= '0;
      seen    <= 8'h00;
      pop_cnt <= 8'h00;
    end else begin
      wp      <= push ? wp + AW'(1) : wp;
      rp      <= pop ? rp + AW'(1) : rp;
      level   <= level + (AW+1)'(push) - (AW+1)'(pop);
      seen    <= (seen_clr ? 8'h00 : seen) | (pop ? Y : 8'h00);
      pop_cnt <= pop_cnt + 8'(pop);
    end
endmodule

// File: tb/tb_pri_dec3x8_buf.sv
// tb_pri_dec3x8_buf: randomized and directed checks of pri_dec3x8_buf against a queue model
module tb_pri_dec3x8_buf;
  localparam int DEPTH = 4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, seen_clr;
  logic [2:0] in_idx;
  logic       in_ready, out_valid;
  logic [7:0] Y, seen, pop_cnt;
  logic [$clog2(DEPTH):0] level;
  int n_chk = 0;
  int n_err = 0;
  logic [2:0] q[$];
  logic [7:0] sm = 8'h00;
  logic [7:0] cm = 8'h00;

  pri_dec3x8_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_ready(in_ready),
    .Y(Y), .out_valid(out_valid), .out_ready(out_ready), .seen_clr(seen_clr),
    .seen(seen), .level(level), .pop_cnt(pop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      sm = 8'h00;
      cm = 8'h00;
    end else begin
      automatic bit do_push = in_valid && q.size() < DEPTH;
      automatic bit do_pop  = out_ready && q.size() > 0;
      if (seen_clr) sm = 8'h00;
      if (do_pop) begin
        sm = sm | (8'h01 << q[0]);
        void'(q.pop_front());
        cm = cm + 8'h01;
      end
      if (do_push) q.push_back(in_idx);
    end

  always @(negedge clk) begin
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("Y", 32'(Y), q.size() > 0 ? 32'(8'h01 << q[0]) : 32'h0);
    chk("seen", 32'(seen), 32'(sm));
    chk("pop_cnt", 32'(pop_cnt), 32'(cm));
  end

  initial begin
    logic [7:0] seq [4];
    seq = '{8'h01, 8'h80, 8'h08, 8'h02};
    rst = 1'b1; in_valid = 1'b0; in_idx = 3'd0; out_ready = 1'b0; seen_clr = 1'b0;
    repeat (2) tick;
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_Y", 32'(Y), 0);
    rst = 1'b0;
    in_valid = 1'b1; in_idx = 3'd5;
    tick;
    in_valid = 1'b0;
    chk("r33_valid", 32'(out_valid), 1);
    chk("r33_level", 32'(level), 1);
    for (int i = 0; i < 10; i++) begin
      chk("r33_hold_Y", 32'(Y), 32'h20);
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("r33_seen", 32'(seen), 32'h20);
    in_valid = 1'b1;
    foreach (seq[i]) begin
      in_idx = i == 0 ? 3'd0 : i == 1 ? 3'd7 : i == 2 ? 3'd3 : 3'd1;
      tick;
    end
    chk("r34_level", 32'(level), 4);
    chk("r34_in_ready", 32'(in_ready), 0);
    in_idx = 3'd6;
    tick;
    in_valid = 1'b0;
    chk("r34_full_level", 32'(level), 4);
    out_ready = 1'b1;
    foreach (seq[i]) begin
      chk("r34_Y", 32'(Y), 32'(seq[i]));
      tick;
    end
    out_ready = 1'b0;
    chk("r34_empty_valid", 32'(out_valid), 0);
    chk("r34_empty_Y", 32'(Y), 0);
    chk("r34_pop_cnt", 32'(pop_cnt), 5);
    seen_clr = 1'b1;
    tick;
    seen_clr = 1'b0;
    chk("clr_seen", 32'(seen), 0);
    in_valid = 1'b1; in_idx = 3'd2;
    tick;
    in_idx = 3'd6;
    tick;
    chk("r35_level0", 32'(level), 2);
    in_idx = 3'd4; out_ready = 1'b1;
    chk("r35_head", 32'(Y), 32'h04);
    tick;
    in_valid = 1'b0;
    chk("r35_level", 32'(level), 2);
    chk("r35_next", 32'(Y), 32'h40);
    tick;
    chk("r36_seen44", 32'(seen), 32'h44);
    chk("r36_last", 32'(Y), 32'h10);
    in_valid = 1'b1; in_idx = 3'd1;
    tick;
    in_valid = 1'b0; seen_clr = 1'b1;
    tick;
    seen_clr = 1'b0; out_ready = 1'b0;
    chk("r36_seen02", 32'(seen), 32'h02);
    chk("r36_pop_cnt", 32'(pop_cnt), 9);
    in_valid = 1'b1; in_idx = 3'($urandom);
    tick;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_idx = 3'($urandom);
      tick;
    end
    chk("r37_pop_cnt", 32'(pop_cnt), 9);
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    chk("r37_drain_cnt", 32'(pop_cnt), 10);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_idx = 3'(i + 3);
      tick;
    end
    in_valid = 1'b0;
    chk("r38_level3", 32'(level), 3);
    #2 rst = 1'b1;
    #1;
    chk("r38_valid", 32'(out_valid), 0);
    chk("r38_Y", 32'(Y), 0);
    chk("r38_level", 32'(level), 0);
    chk("r38_in_ready", 32'(in_ready), 1);
    #2 rst = 1'b0;
    tick;
    chk("r38_no_stale", 32'(out_valid), 0);
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_idx    = 3'($urandom);
      out_ready = i < 500 ? ($urandom % 3) == 0 : i < 1000 ? ($urandom % 3) != 0 : 1'($urandom);
      seen_clr  = ($urandom % 16) == 0;
      tick;
      if (($urandom % 150) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; seen_clr = 1'b0;
    repeat (2) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
